button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the debounced, synchronised button level and the slow-timebase CE strobe produced by the button debounce stage.
- Classifies each press as short or long, and generates auto-repeat pulses while a long press is held.
- Sits between the debounce filter and application control logic (menu stepping, value increment).
- All outputs are registered single-clock-cycle pulses or levels, so downstream logic needs no edge detection.

Parameters:
- LONG_TICKS, 64, number of CE strobes of continuous press before the press counts as long (range 2..2^CNT_W).
- REPEAT_TICKS, 16, number of CE strobes between auto-repeat pulses once long (range 1..2^CNT_W).
- CNT_W, 8, width of the internal tick counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CE  in  1  timebase strobe, one CLK cycle wide; the same strobe that drives the debounce stage.
- BTN_IN  in  1  debounced button level, 1 = pressed; already synchronous to CLK.
- SHORT_P  out  1  one-cycle pulse: button released before reaching long.
- LONG_P  out  1  one-cycle pulse: long threshold reached while still pressed.
- REPEAT_P  out  1  one-cycle pulse: auto-repeat interval elapsed while long-held.
- HELD  out  1  level, 1 while in a long-press state.
- SHORT_CNT  out  8  running count of short presses, wraps 255 -> 0.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. RST has priority over all other inputs.
- Reset values: state IDLE, tick counter 0, SHORT_P/LONG_P/REPEAT_P/HELD = 0, SHORT_CNT = 0.
- State machine, three states:
  - IDLE: BTN_IN=1 -> PRESS with counter cleared. CE is ignored.
  - PRESS:
    - BTN_IN=0 -> IDLE; SHORT_P=1 for the next cycle; SHORT_CNT increments.
    - Else, on CE: if counter == LONG_TICKS-1 -> LONG with counter cleared, and LONG_P=1 for the next cycle; otherwise counter increments.
  - LONG:
    - BTN_IN=0 -> IDLE with no pulse.
    - Else, on CE: if counter == REPEAT_TICKS-1 -> REPEAT_P=1 for the next cycle and counter cleared; otherwise counter increments.
- Latency: every pulse is asserted in the cycle after the clock edge at which its condition was sampled, and lasts exactly one CLK cycle.
- HELD is a registered decode of state == LONG, so it is 1 from the same cycle LONG_P is high until the cycle after release is sampled.
- Simultaneous events:
  - Release and CE in the same cycle: release wins. No LONG_P or REPEAT_P is issued, and SHORT_P is issued if in PRESS.
  - Press and CE in the same cycle in IDLE: the CE is not counted.
- Minimum press: BTN_IN high for one cycle then low gives exactly one SHORT_P.
- Pulse ordering: at most one of SHORT_P, LONG_P, REPEAT_P is high in any cycle.
- With CE held constantly at 1, the block must work as a pure cycle counter.
- Counter width:
  - Counter is CNT_W bits and never wraps, because it is cleared at threshold.
  - Thresholds are compared as CNT_W-bit constants; LONG_TICKS = 2^CNT_W is legal and compares against all-ones.
- SHORT_CNT is 8-bit modulo arithmetic.
- Reset mid-operation: any state returns to IDLE. A pulse that would have been issued is suppressed. If BTN_IN is still 1 after reset, a fresh press begins from the next cycle, with counting restarting from 0.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, PRESS=2'd1, LONG=2'd2.
  - Default threshold constants, so the debounce stage and this block share the timebase definition.
- One natural sub-module: button_tick_counter, a CNT_W-bit counter with clear, CE enable and a terminal-value compare output. It is instantiated once, with the terminal value muxed by state.

Test Plan:
- Bench settings: LONG_TICKS=4, REPEAT_TICKS=2, CE every 4th CLK.
- Short press: BTN_IN high for 3 CE strobes, then low -> SHORT_P high for exactly 1 cycle after the release edge, SHORT_CNT=1, LONG_P/HELD never set.
- Long press with repeat: BTN_IN held for 9 CE strobes ->
  - LONG_P one cycle after the 4th CE.
  - HELD=1 from then on.
  - REPEAT_P after the 6th and 8th CE.
  - On release: HELD drops, and no SHORT_P.
- Release coincident with the 4th CE -> SHORT_P=1, LONG_P=0, SHORT_CNT increments.
- Wrap: 256 short presses -> SHORT_CNT returns to 0. 257 presses -> SHORT_CNT=1.
- Reset mid-long: assert RST for 1 cycle while HELD=1 and BTN_IN=1 ->
  - All outputs 0 the next cycle.
  - LONG_P reissues 4 CE strobes later.
- CE tied to 1, BTN_IN high for 1 cycle -> exactly one SHORT_P. Check that no two pulse outputs are ever high in the same cycle (assertion across all tests).

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encoding and the
// default timebase thresholds also used by the debounce stage.
package button_event_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam int unsigned DEF_LONG_TICKS   = 64;
  localparam int unsigned DEF_REPEAT_TICKS = 16;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned SHORT_CNT_W      = 8;

endpackage

// File: rtl/button_tick_counter.sv
// CE-enabled tick counter with synchronous clear and a terminal-value compare.
module button_tick_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             at_term_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_term_c = (cnt == term);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced presses as short or long and emits auto-repeat pulses
// while a long press is held; all outputs are registered.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic                   BTN_IN,
  output logic                   SHORT_P,
  output logic                   LONG_P,
  output logic                   REPEAT_P,
  output logic                   HELD,
  output logic [SHORT_CNT_W-1:0] SHORT_CNT
);

  // Truncation to CNT_W makes LONG_TICKS = 2^CNT_W compare against all-ones.
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_TICKS - 1);

  state_t           state;
  state_t           state_n;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             at_term_c;
  logic [CNT_W-1:0] term_c;
  logic             short_n;
  logic             long_n;
  logic             repeat_n;

  assign term_c = (state == PRESS) ? LONG_TERM : REPEAT_TERM;

  button_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .term      (term_c),
    .at_term_c (at_term_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Release is tested before CE so a coincident release always wins.
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    short_n  = 1'b0;
    long_n   = 1'b0;
    repeat_n = 1'b0;
    case (state)
      IDLE: begin
        if (BTN_IN) begin
          state_n = PRESS;
          cnt_clr = 1'b1;
        end
      end
      PRESS: begin
        if (!BTN_IN) begin
          state_n = IDLE;
          short_n = 1'b1;
        end else if (CE) begin
          if (at_term_c) begin
            state_n = LONG;
            cnt_clr = 1'b1;
            long_n  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LONG: begin
        if (!BTN_IN) begin
          state_n = IDLE;
        end else if (CE) begin
          if (at_term_c) begin
            repeat_n = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SHORT_P   <= 1'b0;
      LONG_P    <= 1'b0;
      REPEAT_P  <= 1'b0;
      HELD      <= 1'b0;
      SHORT_CNT <= '0;
    end else begin
      SHORT_P  <= short_n;
      LONG_P   <= long_n;
      REPEAT_P <= repeat_n;
      HELD     <= (state_n == LONG);
      if (short_n) begin
        SHORT_CNT <= SHORT_CNT + SHORT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: press-duration reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_button_event_decoder;

  localparam int unsigned LT = 4;
  localparam int unsigned RT = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       BTN_IN;
  logic       SHORT_P;
  logic       LONG_P;
  logic       REPEAT_P;
  logic       HELD;
  logic [7:0] SHORT_CNT;

  button_event_decoder #(
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .CNT_W        (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .BTN_IN    (BTN_IN),
    .SHORT_P   (SHORT_P),
    .LONG_P    (LONG_P),
    .REPEAT_P  (REPEAT_P),
    .HELD      (HELD),
    .SHORT_CNT (SHORT_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference model: counts CE strobes seen while pressed (press cycle excluded).
  bit         m_pressed;
  int         m_ticks;
  logic       e_short, e_long, e_rep, e_held;
  logic [7:0] e_cnt;

  initial begin
    m_pressed = 0; m_ticks = 0;
    e_short = 0; e_long = 0; e_rep = 0; e_held = 0; e_cnt = 0;
    forever begin
      @(posedge CLK);
      e_short = 0; e_long = 0; e_rep = 0;
      if (RST) begin
        m_pressed = 0; m_ticks = 0; e_cnt = 0;
      end else if (!m_pressed) begin
        if (BTN_IN) begin
          m_pressed = 1; m_ticks = 0;
        end
      end else if (!BTN_IN) begin
        if (m_ticks < int'(LT)) begin
          e_short = 1;
          e_cnt   = e_cnt + 8'd1;
        end
        m_pressed = 0; m_ticks = 0;
      end else if (CE) begin
        m_ticks++;
        if (m_ticks == int'(LT)) e_long = 1;
        else if (m_ticks > int'(LT) && ((m_ticks - int'(LT)) % int'(RT)) == 0) e_rep = 1;
      end
      e_held = m_pressed && (m_ticks >= int'(LT));
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int n_short  = 0, n_long = 0, n_rep = 0, n_held = 0;
  int phase    = 0;
  int ce_mode  = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    if (chk_en) begin
      check("short_p", int'(SHORT_P), int'(e_short));
      check("long_p", int'(LONG_P), int'(e_long));
      check("repeat_p", int'(REPEAT_P), int'(e_rep));
      check("held", int'(HELD), int'(e_held));
      check("short_cnt", int'(SHORT_CNT), int'(e_cnt));
      check("one_pulse", int'((int'(SHORT_P) + int'(LONG_P) + int'(REPEAT_P)) <= 1), 1);
      n_short += int'(SHORT_P);
      n_long  += int'(LONG_P);
      n_rep   += int'(REPEAT_P);
      n_held  += int'(HELD);
    end
  endtask

  function automatic bit ce_pred();
    return ((phase + 1) % 4) == 0;
  endfunction

  // One clock: compare outputs at negedge, then set next inputs after posedge.
  task automatic drive(input logic btn, input logic rst = 1'b0);
    @(negedge CLK);
    compare_cycle();
    @(posedge CLK);
    #1;
    RST    = rst;
    BTN_IN = btn;
    phase++;
    case (ce_mode)
      0:       CE = ((phase % 4) == 0);
      1:       CE = 1'b1;
      default: CE = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  task automatic press_hold(input int n);
    int k = 0;
    drive(1'b1);
    while (k < n) begin
      drive(1'b1);
      if (CE) k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  int b_short, b_long, b_rep, b_held;

  task automatic snap();
    b_short = n_short; b_long = n_long; b_rep = n_rep; b_held = n_held;
  endtask

  initial begin
    RST = 1'b1; BTN_IN = 1'b0; CE = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk_en = 1;
    check("rst_short_p", int'(SHORT_P), 0);
    check("rst_held", int'(HELD), 0);
    check("rst_short_cnt", int'(SHORT_CNT), 0);
    idle(3);

    // Short press of 3 CE strobes
    snap();
    press_hold(3);
    idle(5);
    check("short_cnt_pulses", n_short - b_short, 1);
    check("short_no_long", n_long - b_long, 0);
    check("short_no_held", n_held - b_held, 0);
    check("short_cnt_1", int'(SHORT_CNT), 1);

    // Long press held for 9 CE strobes
    snap();
    press_hold(9);
    idle(5);
    check("long_pulses", n_long - b_long, 1);
    check("long_repeats", n_rep - b_rep, 2);
    check("long_no_short", n_short - b_short, 0);
    check("long_held_cycles", n_held - b_held, 21);
    check("long_held_dropped", int'(HELD), 0);

    // Release coincident with the 4th CE
    snap();
    press_hold(3);
    while (!ce_pred()) drive(1'b1);
    drive(1'b0);
    idle(5);
    check("coinc_short", n_short - b_short, 1);
    check("coinc_no_long", n_long - b_long, 0);
    check("coinc_short_cnt", int'(SHORT_CNT), 2);

    // Reset while long-held with button still pressed
    press_hold(5);
    drive(1'b1);
    check("pre_rst_held", int'(HELD), 1);
    drive(1'b1, 1'b1);
    drive(1'b1);
    check("post_rst_held", int'(HELD), 0);
    check("post_rst_pulses", int'(SHORT_P) + int'(LONG_P) + int'(REPEAT_P), 0);
    check("post_rst_cnt", int'(SHORT_CNT), 0);
    begin
      int  k = 0;
      bit  first = 1;
      bit  seen = 0;
      logic was_ce;
      for (int i = 0; i < 60 && !seen; i++) begin
        was_ce = CE;
        drive(1'b1);
        if (!first && was_ce) k++;
        first = 0;
        if (LONG_P) seen = 1;
      end
      check("rst_long_seen", int'(seen), 1);
      check("rst_long_ce_count", k, 4);
    end
    idle(4);

    // CE tied high, single-cycle press
    ce_mode = 1;
    snap();
    drive(1'b1);
    idle(4);
    check("ce1_short", n_short - b_short, 1);
    check("ce1_no_long", n_long - b_long, 0);
    check("ce1_short_cnt", int'(SHORT_CNT), 1);
    ce_mode = 0;

    // SHORT_CNT wrap
    drive(1'b0, 1'b1);
    drive(1'b0);
    repeat (256) begin
      drive(1'b1);
      drive(1'b0);
    end
    idle(2);
    check("wrap_256", int'(SHORT_CNT), 0);
    drive(1'b1);
    idle(3);
    check("wrap_257", int'(SHORT_CNT), 1);

    // Randomized presses with random CE and occasional reset
    ce_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) drive(1'b1, 1'b1);
      press_hold(int'($urandom_range(0, 9)));
      idle(int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 99) == 0));
    end
    ce_mode = 1;
    press_hold(9);
    idle(3);
    drive(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
